wishbone_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter for the SoC. It sits between the CPU instruction-fetch port (master 0) and data port (master 1) on one side and the shared block-RAM memory on the other. It grants whole bus tenures, delimited by `cyc`, in round-robin order. A watchdog converts an unanswered strobe into a bus error.

---
 rtl/wishbone_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wishbone_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
// Two-master / one-slave Wishbone arbiter. Whole bus tenures (delimited by
// cyc) are granted in round-robin order; a granted tenure cannot be
// preempted. A watchdog turns a strobe that the slave leaves unanswered for
// TIMEOUT_CYCLES cycles into a one-cycle err to the owning master.
//
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   m0_* / m1_*               master ports (cyc/stb/we/adr/dat/sel in,
//                             dat/ack/err/rty out); m0 = ifetch, m1 = data
//   s_*                       slave port toward the block-RAM
// Parameter
//   TIMEOUT_CYCLES            0 disables the watchdog, valid range 0..255
module wishbone_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

    localparam logic       WD_EN    = (TIMEOUT_CYCLES != 0);
    // Count value at which the next unanswered strobe cycle times out.
    localparam logic [7:0] CNT_LAST = WD_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

    state_e      state_q, state_d;
    logic        last_q, last_d;     // most recently granted master
    logic [7:0]  cnt_q, cnt_d;

    logic        granted, own1;
    logic        g_cyc, g_stb, g_we;
    logic [31:0] g_adr, g_dat;
    logic [3:0]  g_sel;
    logic        resp, unans, timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;         // master 0 wins the first contention
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        granted = (state_q != IDLE);
        own1    = (state_q == GRANT1);

        g_cyc = own1 ? m1_cyc_i : m0_cyc_i;
        g_stb = own1 ? m1_stb_i : m0_stb_i;
        g_we  = own1 ? m1_we_i  : m0_we_i;
        g_adr = own1 ? m1_adr_i : m0_adr_i;
        g_dat = own1 ? m1_dat_i : m0_dat_i;
        g_sel = own1 ? m1_sel_i : m0_sel_i;

        resp    = s_ack_i | s_err_i | s_rty_i;
        unans   = granted & g_cyc & g_stb & ~resp;
        // A slave response in the timeout cycle wins: unans is already low.
        timeout = WD_EN & unans & (cnt_q == CNT_LAST);

        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;

        if (granted) begin
            s_cyc_o = g_cyc;
            // Strobe is withdrawn in the timeout cycle so the slave sees the
            // access abandoned at the same time the master sees err.
            s_stb_o = g_cyc & g_stb & ~timeout;
            s_we_o  = g_we;
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            if (own1) begin
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | timeout;
                m1_rty_o = s_rty_i;
            end else begin
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | timeout;
                m0_rty_o = s_rty_i;
            end
        end

        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                // On contention the master that was not served last wins.
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (!g_cyc) state_d = IDLE;
                cnt_d = (WD_EN && unans && !timeout) ? cnt_q + 8'd1 : 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios then random traffic, each
// cycle compared against a tenure-level reference model with a block-RAM
// style slave (registered ack, one idle cycle after each ack, no ack for
// addresses 0xFxxxxxxx).
module tb_wishbone_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [31:0] adr [2];
    logic [31:0] wdat[2];
    logic [3:0]  sel [2];

    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_rdat;
    logic        s_ack, s_err, s_rty;

    wishbone_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
    );

    int errors, checks;

    // Reference model: who owns the bus (-1 = nobody), who was served
    // last, and how many consecutive unanswered strobe cycles have passed.
    int own, last, run;

    // Slave memory and the request it saw at the last sample point.
    logic [31:0] mem [256];
    logic        sreq, swe;
    logic [31:0] sadr, sdat;
    logic [3:0]  ssel;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own = -1;
        last = 1;
        run = 0;
        s_ack = 1'b0;
    endtask

    // Compare all outputs mid-cycle and latch the slave-side request.
    task automatic settle();
        logic [70:0] es;
        logic [34:0] e0, e1;
        logic        un, to;
        int          g;
        @(negedge clk);
        es = '0; e0 = '0; e1 = '0; to = 1'b0;
        if (own >= 0) begin
            g  = own;
            un = cyc[g] && stb[g] && !(s_ack || s_err || s_rty);
            // err lands on every TO-th consecutive unanswered strobe cycle.
            to = un && (((run + 1) % TO) == 0);
            es = {cyc[g], cyc[g] & stb[g] & ~to, we[g], adr[g], wdat[g], sel[g]};
            if (g == 0) e0 = {s_rdat, s_ack, s_err | to, s_rty};
            else        e1 = {s_rdat, s_ack, s_err | to, s_rty};
        end
        chk("slave_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}), 128'(es));
        chk("m0_resp", 128'({m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o}), 128'(e0));
        chk("m1_resp", 128'({m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o}), 128'(e1));
        sreq = s_cyc_o & s_stb_o;
        swe  = s_we_o;
        sadr = s_adr_o;
        sdat = s_dat_o;
        ssel = s_sel_o;
    endtask

    // Advance one clock: model and slave update just after the edge.
    task automatic tick();
        logic [7:0] idx;
        @(posedge clk);
        #1;
        if (!rst_ni) begin
            model_reset();
        end else begin
            if (own < 0) begin
                run = 0;
                if (cyc[0] && cyc[1]) own = 1 - last;
                else if (cyc[0])      own = 0;
                else if (cyc[1])      own = 1;
                if (own >= 0) last = own;
            end else begin
                if (cyc[own] && stb[own] && !(s_ack || s_err || s_rty)) run = run + 1;
                else run = 0;
                if (!cyc[own]) own = -1;
            end
            if (sreq && !s_ack && sadr[31:28] != 4'hF) begin
                idx    = sadr[9:2];
                s_ack  = 1'b1;
                s_rdat = mem[idx];
                if (swe)
                    for (int b = 0; b < 4; b++)
                        if (ssel[b]) mem[idx][8*b +: 8] = sdat[8*b +: 8];
            end else begin
                s_ack = 1'b0;
            end
        end
    endtask

    task automatic wait_ack(input int m, input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            settle();
            if ((m == 0) ? m0_ack_o : m1_ack_o) got = 1'b1;
            tick();
        end
    endtask

    task automatic idle_bus();
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 1'b0; stb[m] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            settle(); tick();
        end
    endtask

    initial begin
        bit got;
        errors = 0; checks = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEADBEEF;
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 0; stb[m] = 0; we[m] = 0; adr[m] = '0; wdat[m] = '0; sel[m] = 4'hF;
        end
        s_rdat = '0; s_err = 0; s_rty = 0;
        sreq = 0; swe = 0; sadr = '0; sdat = '0; ssel = '0;
        rst_ni = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("reset_outputs", 128'({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 128'(0));
        settle(); tick();
        rst_ni = 1'b1;

        // Simultaneous requests out of reset
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h20;
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h24;
        settle(); chk("rr_idle", 128'(s_cyc_o), 128'(0)); tick();
        settle(); chk("rr_first_m0", 128'({s_cyc_o, s_adr_o}), 128'({1'b1, 32'h20})); tick();
        settle(); chk("rr_m0_ack", 128'({m0_ack_o, m1_ack_o}), 128'(2'b10)); tick();
        cyc[0] = 0; stb[0] = 0;
        settle(); chk("rr_drop_cyc", 128'({s_cyc_o, s_stb_o}), 128'(0)); tick();
        settle(); chk("rr_gap_idle", 128'(s_cyc_o), 128'(0)); tick();
        settle(); chk("rr_second_m1", 128'({s_cyc_o, s_adr_o}), 128'({1'b1, 32'h24})); tick();
        settle(); tick();
        cyc[1] = 0; stb[1] = 0;
        settle(); tick();
        cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
        settle(); tick();
        settle(); chk("rr_third_m0", 128'({s_cyc_o, s_adr_o}), 128'({1'b1, 32'h20})); tick();
        idle_bus();

        // Single read
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h10;
        settle(); chk("rd_no_stb_yet", 128'(s_stb_o), 128'(0)); tick();
        settle(); chk("rd_stb", 128'({s_stb_o, m0_ack_o}), 128'(2'b10)); tick();
        settle();
        chk("rd_ack", 128'({m0_ack_o, m1_ack_o}), 128'(2'b10));
        chk("rd_data", 128'(m0_dat_o), 128'(32'hDEADBEEF));
        tick();
        idle_bus();

        // Tenure locking: master 1 writes three words while master 0 waits
        cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'b0011;
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h44;
        adr[1] = 32'h40; wdat[1] = 32'hAAAA_0000;
        settle(); tick();
        for (int k = 0; k < 3; k++) begin
            adr[1]  = 32'h40 + 32'(4 * k);
            wdat[1] = 32'hAAAA_0000 + 32'(k);
            wait_ack(1, 8, got);
            chk("lock_write_ack", 128'(got), 128'(1));
        end
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        settle(); chk("lock_release", 128'({s_cyc_o, m0_ack_o}), 128'(0)); tick();
        settle(); chk("lock_gap_idle", 128'(s_cyc_o), 128'(0)); tick();
        settle(); chk("lock_m0_grant", 128'({s_cyc_o, s_adr_o}), 128'({1'b1, 32'h44})); tick();
        chk("lock_mem0", 128'(mem[16]), 128'(32'h1000_0000));
        chk("lock_mem2", 128'(mem[18]), 128'(32'h1000_0002));
        idle_bus();

        // Watchdog: unanswered strobe held for many cycles
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'hF000_0000;
        settle(); tick();
        for (int c = 1; c <= 11; c++) begin
            settle();
            chk("to_err", 128'(m0_err_o), 128'((c % TO) == 0));
            chk("to_stb", 128'(s_stb_o), 128'((c % TO) != 0));
            tick();
        end
        s_rty = 1;
        settle();
        chk("to_prio", 128'({m0_rty_o, m0_err_o, s_stb_o}), 128'(3'b101));
        tick();
        s_rty = 0;
        idle_bus();

        // Response passthrough during a master 1 tenure
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'hF000_0004;
        settle(); tick();
        settle(); tick();
        s_rty = 1;
        settle(); chk("pass_rty", 128'({m1_rty_o, m0_rty_o}), 128'(2'b10)); tick();
        s_rty = 0; s_err = 1;
        settle(); chk("pass_err", 128'({m1_err_o, m0_err_o}), 128'(2'b10)); tick();
        s_err = 0;

        // Reset in the middle of the master 1 tenure
        settle(); tick();
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_bus", 128'({s_cyc_o, s_stb_o}), 128'(0));
        chk("rst_mid_resp", 128'({m1_ack_o, m1_err_o, m1_rty_o, m0_ack_o, m0_err_o, m0_rty_o}), 128'(0));
        model_reset();
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h20;
        settle(); tick();
        rst_ni = 1'b1;
        settle(); tick();
        settle(); chk("rst_rr_m0", 128'({s_cyc_o, s_adr_o}), 128'({1'b1, 32'h20})); tick();
        idle_bus();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (cyc[m]) begin
                    if ($urandom % 8 == 0) begin cyc[m] = 0; stb[m] = 0; end
                    else stb[m] = ($urandom % 4) != 0;
                end else if ($urandom % 3 == 0) begin
                    cyc[m] = 1; stb[m] = 1;
                end
                if ($urandom % 2 == 1) begin
                    adr[m]  = ($urandom % 5 == 0) ? (32'hF000_0000 | ($urandom & 32'hFFC))
                                                  : {22'b0, 8'($urandom), 2'b00};
                    wdat[m] = $urandom;
                    we[m]   = 1'($urandom);
                    sel[m]  = 4'($urandom);
                end
            end
            s_err = ($urandom % 12) == 0;
            s_rty = ($urandom % 12) == 0;
            settle(); tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
